// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronized line, mid-bit sampling, framing-error
// and overrun reporting, with all outputs registered.
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_PERIOD = 15
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  rx,
  input  logic                  clr_rdy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rdy,
  output logic                  frm_err,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(BAUD_PERIOD + 1) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_PERIOD);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_PERIOD / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                  r_rx_meta;
  logic                  r_rx_s;
  state_t                r_state;
  logic [CNT_W-1:0]      r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rdy;
  logic                  r_frm_err;
  logic                  r_overrun;

  state_t                w_state;
  logic [CNT_W-1:0]      w_baud;
  logic [BIT_W-1:0]      w_bit;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_rx_data;
  logic                  w_rdy;
  logic                  w_frm_err;
  logic                  w_overrun;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_frm_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_baud    <= w_baud;
      r_bit     <= w_bit;
      r_shift   <= w_shift;
      r_rx_data <= w_rx_data;
      r_rdy     <= w_rdy;
      r_frm_err <= w_frm_err;
      r_overrun <= w_overrun;
    end
  end

  // Next-state and output logic; a completion in STOP overrides clr_rdy.
  always_comb begin
    w_state   = r_state;
    w_baud    = r_baud + CNT_W'(1);
    w_bit     = r_bit;
    w_shift   = r_shift;
    w_rx_data = r_rx_data;
    w_rdy     = clr_rdy ? 1'b0 : r_rdy;
    w_frm_err = r_frm_err;
    w_overrun = clr_rdy ? 1'b0 : r_overrun;

    case (r_state)
      S_IDLE: begin
        w_baud = '0;
        if (!r_rx_s) begin
          w_state = S_START;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_START: begin
        if (r_baud == BAUD_HALF) begin
          w_baud = '0;
          w_bit  = '0;
          if (r_rx_s) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_DATA;
          end
        end else begin
          w_state = S_START;
        end
      end
      S_DATA: begin
        if (r_baud == BAUD_FULL) begin
          w_baud  = '0;
          w_shift = {r_rx_s, r_shift[DATA_WIDTH-1:1]};
          w_bit   = r_bit + BIT_W'(1);
          if (r_bit == BIT_LAST) begin
            w_state = S_STOP;
          end else begin
            w_state = S_DATA;
          end
        end else begin
          w_state = S_DATA;
        end
      end
      S_STOP: begin
        if (r_baud == BAUD_FULL) begin
          w_state = S_IDLE;
          w_baud  = '0;
          if (r_rx_s) begin
            w_rx_data = r_shift;
            w_rdy     = 1'b1;
            w_frm_err = 1'b0;
            w_overrun = r_rdy & ~clr_rdy;
          end else begin
            w_frm_err = 1'b1;
          end
        end else begin
          w_state = S_STOP;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_baud  = '0;
      end
    endcase
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural transmitter drives frames and
// a scoreboard queue holds the output state each frame should leave behind.
module tb_uart_rx;

  localparam int DW      = 8;
  localparam int BP      = 15;
  localparam int BIT_CYC = BP + 1;
  localparam int LAT     = 2 + (BP / 2 + 1) + (DW + 1) * BIT_CYC + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          rdy;
    logic          frm;
    logic          ovr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          rx;
  logic          clr_rdy;
  logic [DW-1:0] rx_data;
  logic          rdy;
  logic          frm_err;
  logic          overrun;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   t_start;
  int   t_rdy  = -1;
  logic rdy_q  = 1'b0;
  exp_t sb_q[$];

  uart_rx #(.DATA_WIDTH(DW), .BAUD_PERIOD(BP)) dut (
    .clk     (clk),
    .rst_l   (rst_l),
    .rx      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle on which rdy rises, for the latency check.
  always @(negedge clk) begin
    if (rdy && !rdy_q) t_rdy = cyc;
    rdy_q = rdy;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".rx_data"}, 32'(rx_data), 32'(e.data));
      check_eq({tag, ".rdy"},     32'(rdy),     32'(e.rdy));
      check_eq({tag, ".frm_err"}, 32'(frm_err), 32'(e.frm));
      check_eq({tag, ".overrun"}, 32'(overrun), 32'(e.ovr));
    end
  endtask

  // All line drive starts 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy = 1'b0;
  endtask

  initial begin
    int lat;
    logic [DW-1:0] words [3];
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h81;

    rst_l   = 1'b0;
    rx      = 1'b1;
    clr_rdy = 1'b0;
    #12;
    check_eq("reset.rx_data", 32'(rx_data), 32'h0);
    check_eq("reset.rdy",     32'(rdy),     32'h0);
    check_eq("reset.frm_err", 32'(frm_err), 32'h0);
    check_eq("reset.overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Good frame plus latency from line falling edge.
    t_rdy = -1;
    sb_q.push_back('{data: 8'hA5, rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
    send_frame(8'hA5, 1'b1);
    check_frame("a5");
    lat = (t_rdy < 0) ? -1 : (t_rdy - t_start);
    check_eq("a5.latency", (lat >= LAT - 1 && lat <= LAT + 1) ? 32'(LAT) : 32'(lat), 32'(LAT));
    pulse_clr();
    check_eq("a5.clr_rdy", 32'(rdy), 32'h0);

    // Short low glitch is a false start.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    sb_q.push_back('{data: 8'hA5, rdy: 1'b0, frm: 1'b0, ovr: 1'b0});
    check_frame("glitch");

    // Good 0x11, then 0x3C with a bad stop bit.
    sb_q.push_back('{data: 8'h11, rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
    send_frame(8'h11, 1'b1);
    check_frame("x11");
    sb_q.push_back('{data: 8'h11, rdy: 1'b1, frm: 1'b1, ovr: 1'b0});
    send_frame(8'h3C, 1'b0);
    check_frame("x3c_bad_stop");

    // Second good frame without clr_rdy overruns and clears frm_err.
    sb_q.push_back('{data: 8'h22, rdy: 1'b1, frm: 1'b0, ovr: 1'b1});
    send_frame(8'h22, 1'b1);
    check_frame("x22_overrun");
    pulse_clr();
    sb_q.push_back('{data: 8'h22, rdy: 1'b0, frm: 1'b0, ovr: 1'b0});
    check_frame("x22_clr");

    // clr_rdy coinciding with a completion: completion wins, no overrun.
    sb_q.push_back('{data: 8'h33, rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
    send_frame(8'h33, 1'b1);
    check_frame("x33");
    sb_q.push_back('{data: 8'h44, rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1;
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
      end
    join
    check_frame("x44_clr_same_cycle");

    // Reset in the middle of data bit 4 of 0xF0.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (BIT_CYC / 2) @(posedge clk);
    #1;
    rst_l = 1'b0;
    #1;
    check_eq("midrst.rx_data", 32'(rx_data), 32'h0);
    check_eq("midrst.rdy",     32'(rdy),     32'h0);
    check_eq("midrst.frm_err", 32'(frm_err), 32'h0);
    check_eq("midrst.overrun", 32'(overrun), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    sb_q.push_back('{data: 8'h5A, rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
    send_frame(8'h5A, 1'b1);
    check_frame("x5a_after_rst");
    pulse_clr();

    // Loopback words with clr_rdy after each.
    foreach (words[k]) begin
      sb_q.push_back('{data: words[k], rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
      send_frame(words[k], 1'b1);
      check_frame($sformatf("loop%0d", k));
      pulse_clr();
      check_eq($sformatf("loop%0d.clr", k), 32'(rdy), 32'h0);
    end

    // Line stuck low: framing error, no rdy; released during the retry's start bit.
    rx = 1'b0;
    repeat (10 * BIT_CYC) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    sb_q.push_back('{data: 8'h81, rdy: 1'b0, frm: 1'b1, ovr: 1'b0});
    check_frame("stuck_low");
    sb_q.push_back('{data: 8'h96, rdy: 1'b1, frm: 1'b0, ovr: 1'b0});
    send_frame(8'h96, 1'b1);
    check_frame("x96_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
